// File: rtl/im_loader_fetch.sv
// Instruction memory with a streaming program-load port and a byte-addressed fetch port.
// Latency: fetch result on IM/IM_Valid one cycle after an accepted request; one load word per cycle.
// Backpressure: Ld_Ready only while loading, Fetch_Ready only once a program is loaded; unaccepted requests are dropped.
module im_loader_fetch #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Ld_Start,
    input  logic                       Ld_Valid,
    input  logic [DATA_W-1:0]          Ld_Data,
    input  logic                       Ld_Last,
    output logic                       Ld_Ready,
    output logic                       Ld_Done,
    output logic [$clog2(DEPTH+1)-1:0] Ld_Count,
    input  logic                       Fetch_Req,
    input  logic [ADDR_W-1:0]          PC,
    output logic                       Fetch_Ready,
    output logic [DATA_W-1:0]          IM,
    output logic                       IM_Valid,
    output logic                       Fault,
    output logic [1:0]                 Fault_Code
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH-1);

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                ld_fire;
    logic                fetch_fire;
    logic [ADDR_W-3:0]   word_idx;
    logic                misaligned;
    logic                out_of_range;

    assign Ld_Ready    = (state == LOAD);
    assign Ld_Done     = (state == RUN);
    assign Fetch_Ready = (state == RUN);

    assign ld_fire      = Ld_Valid && Ld_Ready;
    assign fetch_fire   = Fetch_Req && Fetch_Ready;
    assign word_idx     = PC[ADDR_W-1:2];
    assign misaligned   = (PC[1:0] != 2'b00);
    // Full-width compare so upper PC bits can never alias back into the array.
    assign out_of_range = ({2'b00, word_idx} >= ADDR_W'(Ld_Count));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= EMPTY;
            Ld_Count <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (Ld_Start) begin
                        state    <= LOAD;
                        Ld_Count <= '0;
                    end
                end
                LOAD: begin
                    if (ld_fire) begin
                        Ld_Count <= Ld_Count + CW'(1);
                        if (Ld_Last || (Ld_Count == LAST_IDX)) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (Ld_Start) begin
                        state    <= LOAD;
                        Ld_Count <= '0;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // The write pointer is Ld_Count itself; the array is deliberately not reset.
    always_ff @(posedge Clk) begin
        if (ld_fire) begin
            mem[Ld_Count[AW-1:0]] <= Ld_Data;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            IM         <= NOP_WORD;
            IM_Valid   <= 1'b0;
            Fault      <= 1'b0;
            Fault_Code <= 2'b00;
        end else begin
            IM_Valid <= fetch_fire;
            if (fetch_fire) begin
                if (misaligned) begin
                    IM         <= NOP_WORD;
                    Fault      <= 1'b1;
                    Fault_Code <= 2'b01;
                end else if (out_of_range) begin
                    IM         <= NOP_WORD;
                    Fault      <= 1'b1;
                    Fault_Code <= 2'b10;
                end else begin
                    IM         <= mem[word_idx[AW-1:0]];
                    Fault      <= 1'b0;
                    Fault_Code <= 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_im_loader_fetch.sv
// Directed bench for im_loader_fetch with a small DEPTH so truncating loads are short.
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
module tb_im_loader_fetch;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Ld_Start, Ld_Valid, Ld_Last;
    logic [31:0]   Ld_Data;
    logic          Ld_Ready, Ld_Done;
    logic [CW-1:0] Ld_Count;
    logic          Fetch_Req;
    logic [31:0]   PC;
    logic          Fetch_Ready;
    logic [31:0]   IM;
    logic          IM_Valid, Fault;
    logic [1:0]    Fault_Code;

    int n_cmp = 0;
    int n_bad = 0;

    im_loader_fetch #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .NOP_WORD(32'h0)) dut (
        .Clk(Clk), .Reset(Reset),
        .Ld_Start(Ld_Start), .Ld_Valid(Ld_Valid), .Ld_Data(Ld_Data), .Ld_Last(Ld_Last),
        .Ld_Ready(Ld_Ready), .Ld_Done(Ld_Done), .Ld_Count(Ld_Count),
        .Fetch_Req(Fetch_Req), .PC(PC), .Fetch_Ready(Fetch_Ready),
        .IM(IM), .IM_Valid(IM_Valid), .Fault(Fault), .Fault_Code(Fault_Code)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ld_ready"},    32'(Ld_Ready),    32'd0);
        chk({tag, ".ld_done"},     32'(Ld_Done),     32'd0);
        chk({tag, ".ld_count"},    32'(Ld_Count),    32'd0);
        chk({tag, ".fetch_ready"}, 32'(Fetch_Ready), 32'd0);
        chk({tag, ".im"},          IM,               32'h0);
        chk({tag, ".im_valid"},    32'(IM_Valid),    32'd0);
        chk({tag, ".fault"},       32'(Fault),       32'd0);
        chk({tag, ".fault_code"},  32'(Fault_Code),  32'd0);
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] im_e, input logic f_e, input logic [1:0] c_e);
        chk({tag, ".valid"}, 32'(IM_Valid),   32'd1);
        chk({tag, ".im"},    IM,              im_e);
        chk({tag, ".fault"}, 32'(Fault),      32'(f_e));
        chk({tag, ".code"},  32'(Fault_Code), 32'(c_e));
    endtask

    initial begin
        logic [31:0] prog [4];
        prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33; prog[3] = 32'h44;

        Reset = 1'b0; Ld_Start = 0; Ld_Valid = 0; Ld_Last = 0; Ld_Data = '0;
        Fetch_Req = 0; PC = '0;
        step(); step();
        chk_reset_vals("rst");

        // Short program load
        Reset = 1'b1;
        Ld_Start = 1'b1;
        step();
        Ld_Start = 1'b0;
        chk("load.ready", 32'(Ld_Ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            Ld_Valid = 1'b1; Ld_Data = prog[i]; Ld_Last = (i == 3);
            chk("load.ready_each", 32'(Ld_Ready), 32'd1);
            chk("load.done_low", 32'(Ld_Done), 32'd0);
            step();
            chk("load.count", 32'(Ld_Count), 32'(i + 1));
        end
        Ld_Valid = 1'b0; Ld_Last = 1'b0;
        chk("load.done", 32'(Ld_Done), 32'd1);
        chk("load.ready_off", 32'(Ld_Ready), 32'd0);
        chk("load.fetch_ready", 32'(Fetch_Ready), 32'd1);

        // Back-to-back fetches
        Fetch_Req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PC = 32'(4 * i);
            step();
            chk_fetch("fetch.seq", prog[i], 1'b0, 2'b00);
        end
        Fetch_Req = 1'b0;
        step();
        chk("fetch.idle_valid", 32'(IM_Valid), 32'd0);
        chk("fetch.idle_hold", IM, 32'h44);

        // Fault cases
        Fetch_Req = 1'b1;
        PC = 32'd6;      step(); chk_fetch("fault.misalign", 32'h0, 1'b1, 2'b01);
        PC = 32'd16;     step(); chk_fetch("fault.oor16",    32'h0, 1'b1, 2'b10);
        PC = 32'h1000;   step(); chk_fetch("fault.oor1000",  32'h0, 1'b1, 2'b10);
        PC = 32'h1002;   step(); chk_fetch("fault.priority", 32'h0, 1'b1, 2'b01);
        PC = 32'd8;      step(); chk_fetch("fault.recover",  32'h33, 1'b0, 2'b00);
        Fetch_Req = 1'b0;
        step();
        chk("fault.hold_code", 32'(Fault_Code), 32'd0);

        // Reload requested together with a fetch
        Ld_Start = 1'b1; Fetch_Req = 1'b1; PC = 32'd0;
        step();
        Ld_Start = 1'b0;
        chk_fetch("reload.last_fetch", 32'h11, 1'b0, 2'b00);
        chk("reload.fetch_ready", 32'(Fetch_Ready), 32'd0);
        chk("reload.done", 32'(Ld_Done), 32'd0);
        chk("reload.count", 32'(Ld_Count), 32'd0);
        step();
        chk("reload.dropped_valid", 32'(IM_Valid), 32'd0);
        chk("reload.dropped_hold", IM, 32'h11);
        Fetch_Req = 1'b0;

        // Ld_Last without Ld_Valid and Ld_Start during LOAD are both no-ops
        Ld_Last = 1'b1; Ld_Start = 1'b1;
        step();
        Ld_Last = 1'b0; Ld_Start = 1'b0;
        chk("noop.count", 32'(Ld_Count), 32'd0);
        chk("noop.ready", 32'(Ld_Ready), 32'd1);

        // Truncating load: DEPTH+3 words, Ld_Last never set
        for (int i = 0; i < DEPTH + 3; i++) begin
            Ld_Valid = 1'b1; Ld_Data = 32'hA0 + 32'(i);
            chk("trunc.ready", 32'(Ld_Ready), 32'(i < DEPTH));
            step();
        end
        Ld_Valid = 1'b0;
        chk("trunc.count", 32'(Ld_Count), 32'(DEPTH));
        chk("trunc.done", 32'(Ld_Done), 32'd1);
        chk("trunc.ready_off", 32'(Ld_Ready), 32'd0);
        Fetch_Req = 1'b1;
        PC = 32'(4 * (DEPTH - 1)); step(); chk_fetch("trunc.last_word", 32'hA7, 1'b0, 2'b00);
        PC = 32'(4 * DEPTH);       step(); chk_fetch("trunc.past_end",  32'h0,  1'b1, 2'b10);
        PC = 32'd4;                step(); chk_fetch("trunc.word1",     32'hA1, 1'b0, 2'b00);
        Fetch_Req = 1'b0;

        // Reset in the middle of a load
        Ld_Start = 1'b1;
        step();
        Ld_Start = 1'b0;
        Ld_Valid = 1'b1; Ld_Data = 32'h55; step();
        Ld_Data = 32'h66; step();
        chk("midrst.count_pre", 32'(Ld_Count), 32'd2);
        Ld_Data = 32'h77;
        #2 Reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        Ld_Valid = 1'b0;
        step();
        Reset = 1'b1;
        Fetch_Req = 1'b1; PC = 32'd0;
        step();
        chk("midrst.fetch_blocked", 32'(Fetch_Ready), 32'd0);
        step();
        chk("midrst.no_valid", 32'(IM_Valid), 32'd0);
        Fetch_Req = 1'b0;

        // One-word reload: old array contents stay unreachable
        Ld_Start = 1'b1;
        step();
        Ld_Start = 1'b0;
        Ld_Valid = 1'b1; Ld_Last = 1'b1; Ld_Data = 32'h99;
        step();
        Ld_Valid = 1'b0; Ld_Last = 1'b0;
        chk("one.count", 32'(Ld_Count), 32'd1);
        Fetch_Req = 1'b1;
        PC = 32'd4; step(); chk_fetch("one.pc4", 32'h0, 1'b1, 2'b10);
        PC = 32'd0; step(); chk_fetch("one.pc0", 32'h99, 1'b0, 2'b00);
        Fetch_Req = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
